// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using one double-dabble
// step per clock. An accepted start captures the input magnitude, and the
// result is ready BIN_WIDTH cycles later. The result is saturated to all 9s
// when the magnitude needs more than DIGITS digits.
//
// Ports
//   clock    : rising-edge clock
//   reset    : synchronous active-low reset
//   start    : conversion request, accepted only while idle
//   bin      : binary value, captured on the accepted start edge
//   busy     : high while a conversion is shifting
//   done     : one-cycle pulse when bcd/negative/overflow/blank are updated
//   bcd      : BCD magnitude, digit 0 in bits [3:0]
//   negative : result is negative (SIGNED builds only)
//   overflow : magnitude did not fit in DIGITS digits
//   blank    : per-digit leading-zero flags, bit 0 always 0
module bin2bcd_seq #(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [BIN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]     work;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_q;
  logic                 neg_q;

  logic                 accept;
  logic                 last;
  logic                 in_neg;
  logic [BIN_WIDTH-1:0] mag_in;
  logic [BCD_W-1:0]     work_adj;
  logic [BCD_W-1:0]     work_shift;
  logic                 ovf_shift;
  logic [DIGITS-1:0]    blank_calc;
  logic                 zero_above;

  assign busy = (state == SHIFT);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; start is only honoured from IDLE, last step returns to IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input magnitude; the negation is held unsigned so the most negative
  // value maps to 2^(BIN_WIDTH-1) without wrapping
  always_comb begin
    in_neg = (SIGNED != 0) && bin[BIN_WIDTH-1];
    mag_in = in_neg ? ((~bin) + BIN_WIDTH'(1)) : bin;
  end

  // Double-dabble correction: digits >= 5 get +3 before the shift
  always_comb begin
    work_adj = work;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift step; a 1 leaving the top digit means the value exceeds DIGITS digits
  always_comb begin
    work_shift = {work_adj[BCD_W-2:0], mag[BIN_WIDTH-1]};
    ovf_shift  = ovf_q | work_adj[BCD_W-1];
  end

  // Leading-zero flags from the most significant digit downward
  always_comb begin
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above    = zero_above & (work_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_above;
    end
    blank_calc[0] = 1'b0;
    if (ovf_shift) begin
      blank_calc = '0;
    end
  end

  // Datapath and registered result outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      mag      <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      blank    <= BLANK_RST;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mag   <= mag_in;
        work  <= '0;
        ovf_q <= 1'b0;
        // A negative input always has a nonzero magnitude
        neg_q <= in_neg;
        cnt   <= CNT_LOAD;
      end else if (state == SHIFT) begin
        mag   <= {mag[BIN_WIDTH-2:0], 1'b0};
        work  <= work_shift;
        ovf_q <= ovf_shift;
        cnt   <= cnt - CNT_W'(1);
        if (last) begin
          done     <= 1'b1;
          bcd      <= ovf_shift ? ALL_NINES : work_shift;
          overflow <= ovf_shift;
          negative <= neg_q;
          blank    <= blank_calc;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: checks bin2bcd_seq (unsigned and signed builds) against a
// decimal reference model computed with plain integer arithmetic.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
    logic [3:0]  blank;
  } res_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [13:0] bin0, bin1;

  logic        busy0, done0, neg0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;
  logic        busy1, done1, neg1, ovf1;
  logic [15:0] bcd1;
  logic [3:0]  blank1;

  logic        sel;
  logic        m_busy, m_done, m_neg, m_ovf;
  logic [15:0] m_bcd;
  logic [3:0]  m_blank;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bin2bcd_seq #(.BIN_WIDTH(14), .DIGITS(4), .SIGNED(0)) u_dut (
    .clock(clock), .reset(reset), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .negative(neg0),
    .overflow(ovf0), .blank(blank0)
  );

  bin2bcd_seq #(.BIN_WIDTH(14), .DIGITS(4), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset(reset), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .negative(neg1),
    .overflow(ovf1), .blank(blank1)
  );

  always_comb begin
    if (sel) begin
      m_busy = busy1; m_done = done1; m_bcd = bcd1;
      m_neg  = neg1;  m_ovf  = ovf1;  m_blank = blank1;
    end else begin
      m_busy = busy0; m_done = done0; m_bcd = bcd0;
      m_neg  = neg0;  m_ovf  = ovf0;  m_blank = blank0;
    end
  end

  // Decimal reference: magnitude, saturation and leading-zero rules
  function automatic res_t model(input bit sgn, input logic [13:0] v);
    res_t r;
    int   mag;
    int   p;
    bit   isneg;
    isneg = sgn && v[13];
    mag   = isneg ? (16384 - int'(v)) : int'(v);
    r.neg = isneg && (mag != 0);
    r.ovf = (mag > 9999);
    r.bcd = '0;
    r.blank = '0;
    if (r.ovf) begin
      r.bcd = 16'h9999;
    end else begin
      p = 1;
      for (int k = 0; k < 4; k++) begin
        r.bcd[4*k +: 4] = 4'((mag / p) % 10);
        if (k >= 1) r.blank[k] = (mag < p);
        p = p * 10;
      end
    end
    return r;
  endfunction

  // One conversion: returns latency (edges after start edge) and busy count
  task automatic run_conv(input bit s, input logic [13:0] v,
                          output int lat, output int busy_cnt, output res_t r);
    sel = s;
    @(negedge clock);
    if (s) begin bin1 = v; start1 = 1'b1; end
    else   begin bin0 = v; start0 = 1'b1; end
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    bin0 = 14'($urandom); bin1 = 14'($urandom);
    lat = -1;
    busy_cnt = m_busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (m_done) begin lat = n; break; end
      if (m_busy) busy_cnt++;
    end
    r = '{bcd: m_bcd, neg: m_neg, ovf: m_ovf, blank: m_blank};
  endtask

  task automatic test_reset();
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; bin0 = '0; bin1 = '0; sel = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({busy0, done0, bcd0, neg0, ovf0, blank0} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110}) begin
      bad++;
      $display("FAIL reset_u: got %h exp %h", {busy0, done0, bcd0, neg0, ovf0, blank0},
               {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110});
    end
    total++;
    if ({busy1, done1, bcd1, neg1, ovf1, blank1} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110}) begin
      bad++;
      $display("FAIL reset_s: got %h exp %h", {busy1, done1, bcd1, neg1, ovf1, blank1},
               {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    res_t r, e;
    run_conv(1'b0, 14'd9999, lat, bc, r);
    e = model(1'b0, 14'd9999);
    total++;
    if (lat !== 14) begin bad++; $display("FAIL basic_latency: got %0d exp 14", lat); end
    total++;
    if (bc !== 14) begin bad++; $display("FAIL basic_busy_cycles: got %0d exp 14", bc); end
    total++;
    if (r !== e) begin bad++; $display("FAIL basic_result: got %h exp %h", r, e); end
    @(posedge clock); #1;
    total++;
    if ({m_done, m_busy} !== 2'b00) begin
      bad++; $display("FAIL basic_done_width: got done/busy %b exp 00", {m_done, m_busy});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    res_t r, e;
    run_conv(1'b0, 14'd0, lat, bc, r);
    e = model(1'b0, 14'd0);
    total++;
    if ({lat, r} !== {14, e}) begin
      bad++; $display("FAIL b2b_first: got lat %0d res %h exp lat 14 res %h", lat, r, e);
    end
    // second start asserted while done is high
    bin0 = 14'd42; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; bin0 = 14'($urandom);
    total++;
    if ({m_done, m_busy} !== 2'b01) begin
      bad++; $display("FAIL b2b_accept: got done/busy %b exp 01", {m_done, m_busy});
    end
    gap = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clock); #1;
      if (m_done) begin gap = n; break; end
    end
    r = '{bcd: m_bcd, neg: m_neg, ovf: m_ovf, blank: m_blank};
    e = model(1'b0, 14'd42);
    total++;
    if ({gap, r} !== {15, e}) begin
      bad++; $display("FAIL b2b_second: got gap %0d res %h exp gap 15 res %h", gap, r, e);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    res_t r, e;
    logic [13:0] v;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 14'd16383 : (i == 1) ? 14'd10000 : 14'($urandom_range(10000, 16383));
      run_conv(1'b0, v, lat, bc, r);
      e = model(1'b0, v);
      total++;
      if ({lat, r} !== {14, e}) begin
        bad++; $display("FAIL overflow v=%0d: got lat %0d res %h exp lat 14 res %h", v, lat, r, e);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones, first;
    res_t r, e;
    sel = 1'b0;
    dones = 0; first = -1; r = '0;
    @(negedge clock);
    bin0 = 14'd123; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin bin0 = 14'd456; start0 = 1'b1; end
      @(posedge clock); #1;
      start0 = 1'b0;
      if (m_done) begin
        dones++;
        if (first < 0) begin
          first = n;
          r = '{bcd: m_bcd, neg: m_neg, ovf: m_ovf, blank: m_blank};
        end
      end
    end
    e = model(1'b0, 14'd123);
    total++;
    if ({dones, first, r} !== {1, 14, e}) begin
      bad++; $display("FAIL ignore_start: got dones %0d lat %0d res %h exp dones 1 lat 14 res %h",
                      dones, first, r, e);
    end
  endtask

  task automatic test_signed();
    int lat, bc;
    res_t r, e;
    logic [13:0] v;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: v = 14'h2000;
        1: v = 14'h3FFF;
        2: v = 14'h1FFF;
        3: v = 14'h0000;
        default: v = 14'($urandom);
      endcase
      run_conv(1'b1, v, lat, bc, r);
      e = model(1'b1, v);
      total++;
      if ({lat, r} !== {14, e}) begin
        bad++; $display("FAIL signed v=%h: got lat %0d res %h exp lat 14 res %h", v, lat, r, e);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    res_t r, e;
    logic [13:0] v;
    for (int i = 0; i < 20; i++) begin
      v = (i < 3) ? 14'(i * 7 + 5) : 14'($urandom_range(0, 9999));
      run_conv(1'b0, v, lat, bc, r);
      e = model(1'b0, v);
      total++;
      if ({lat, r} !== {14, e}) begin
        bad++; $display("FAIL random v=%0d: got lat %0d res %h exp lat 14 res %h", v, lat, r, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] held;
    held = m_bcd;
    sel = 1'b0;
    repeat (5) begin
      @(negedge clock);
      bin0 = 14'($urandom);
    end
    @(posedge clock); #1;
    total++;
    if ({m_bcd, m_done, m_busy} !== {held, 2'b00}) begin
      bad++; $display("FAIL hold: got %h exp %h", {m_bcd, m_done, m_busy}, {held, 2'b00});
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat, bc;
    res_t r, e;
    sel = 1'b0;
    @(negedge clock);
    bin0 = 14'd777; start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    total++;
    if ({busy0, done0, bcd0, neg0, ovf0, blank0} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110}) begin
      bad++;
      $display("FAIL reset_abort_state: got %h exp %h", {busy0, done0, bcd0, neg0, ovf0, blank0},
               {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110});
    end
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done0 || busy0) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_abort_quiet: got %0d active cycles exp 0", dones); end
    run_conv(1'b0, 14'd555, lat, bc, r);
    e = model(1'b0, 14'd555);
    total++;
    if ({lat, r} !== {14, e}) begin
      bad++; $display("FAIL reset_abort_next: got lat %0d res %h exp lat 14 res %h", lat, r, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_signed();
    test_random();
    test_hold();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
